// File: rtl/param_up_down_counter_if.sv
// param_up_down_counter_if: control and status bundle for param_up_down_counter
// master drives: en (step), ud (0 up / 1 down), load, load_val, sat (UDC_SATURATE_EN only)
// slave drives: count (registered), tc (combinational terminal count), wrap (one-cycle pulse)
interface param_up_down_counter_if #(
  parameter int WIDTH = 4
);
  logic en, ud, load;
  logic [WIDTH-1:0] load_val, count;
  logic tc, wrap;
`ifdef UDC_SATURATE_EN
  logic sat;
  modport master(output en, ud, load, load_val, sat, input count, tc, wrap);
  modport slave(input en, ud, load, load_val, sat, output count, tc, wrap);
`else
  modport master(output en, ud, load, load_val, input count, tc, wrap);
  modport slave(input en, ud, load, load_val, output count, tc, wrap);
`endif
endinterface

// File: rtl/param_up_down_counter.sv
// param_up_down_counter: modulo MAX_COUNT+1 up/down counter with load, enable, tc and wrap pulse
// clk: rising-edge clock; clear: asynchronous active-low reset (count=0, wrap=0)
// bus (slave): en/ud/load/load_val in, count/tc/wrap out
// define UDC_SATURATE_EN to add bus.sat, which holds count at the boundary instead of wrapping
module param_up_down_counter #(
  parameter int WIDTH = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input logic clk,
  input logic clear,
  param_up_down_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  logic [WIDTH-1:0] count_q, step_v;
  logic wrap_q, at_bound, sat_on;
`ifdef UDC_SATURATE_EN
  assign sat_on = bus.sat;
`else
  assign sat_on = 1'b0;
`endif
  // at_bound is the wrap point for the current direction; it doubles as tc
  assign at_bound = bus.ud ? (count_q == '0) : (count_q == MAX_V);
  always_comb
    step_v = at_bound ? (sat_on ? count_q : (bus.ud ? MAX_V : '0))
                      : (bus.ud ? count_q - 1'b1 : count_q + 1'b1);
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      count_q <= '0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
      wrap_q <= 1'b0;
    end else begin
      if (bus.en) count_q <= step_v;
      wrap_q <= bus.en && at_bound && !sat_on;
    end
  assign bus.count = count_q;
  assign bus.tc = at_bound;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_param_up_down_counter.sv
// tb_param_up_down_counter: randomized scoreboard bench for a full-range and a mod-10 counter
module tb_param_up_down_counter;
  typedef struct {
    int c0, c1;
    bit w0, w1, t0, t1;
  } exp_t;
  logic clk = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  bit en, ud, load, sat;
  int lv;
  int mx[2] = '{15, 9};
  int mc[2];
  bit mw[2];
  always #5 clk = ~clk;
  param_up_down_counter_if #(.WIDTH(4)) b0();
  param_up_down_counter_if #(.WIDTH(4)) b1();
  param_up_down_counter #(.WIDTH(4)) d0(.clk(clk), .clear(clear), .bus(b0.slave));
  param_up_down_counter #(.WIDTH(4), .MAX_COUNT(9)) d1(.clk(clk), .clear(clear), .bus(b1.slave));
  function automatic void chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endfunction
  function automatic bit sat_eff();
`ifdef UDC_SATURATE_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction
  function automatic void step(input int m, input int c, output int nc, output bit nw);
    bit edge_v;
    edge_v = ud ? (c == 0) : (c == m);
    if (load) begin
      nc = lv > m ? m : lv;
      nw = 1'b0;
    end else if (!en) begin
      nc = c;
      nw = 1'b0;
    end else if (edge_v && sat_eff()) begin
      nc = c;
      nw = 1'b0;
    end else begin
      nc = ud ? (c + m) % (m + 1) : (c + 1) % (m + 1);
      nw = edge_v;
    end
  endfunction
  task automatic apply();
    b0.en = en; b0.ud = ud; b0.load = load; b0.load_val = 4'(lv);
    b1.en = en; b1.ud = ud; b1.load = load; b1.load_val = 4'(lv);
`ifdef UDC_SATURATE_EN
    b0.sat = sat;
    b1.sat = sat;
`endif
  endtask
  function automatic bit tc_of(input int c, input int m);
    return ud ? (c == 0) : (c == m);
  endfunction
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count0", int'(b0.count), e.c0);
      chk("wrap0", int'(b0.wrap), int'(e.w0));
      chk("tc0", int'(b0.tc), int'(e.t0));
      chk("count1", int'(b1.count), e.c1);
      chk("wrap1", int'(b1.wrap), int'(e.w1));
      chk("tc1", int'(b1.tc), int'(e.t1));
    end
  initial begin
    en = 0; ud = 1; load = 0; sat = 0; lv = 0;
    apply();
    #2;
    chk("reset_count0", int'(b0.count), 0);
    chk("reset_wrap0", int'(b0.wrap), 0);
    chk("reset_tc_ud1", int'(b0.tc), 1);
    chk("reset_count1", int'(b1.count), 0);
    chk("reset_wrap1", int'(b1.wrap), 0);
    #6 clear = 1'b1;
    mc = '{0, 0};
    mw = '{0, 0};
    ud = 0;
    apply();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        int nc;
        bit nw;
        step(mx[k], mc[k], nc, nw);
        mc[k] = nc;
        mw[k] = nw;
      end
      if (n % 97 == 50) begin
        clear = 1'b0;
        #1;
        chk("async_count0", int'(b0.count), 0);
        chk("async_wrap0", int'(b0.wrap), 0);
        chk("async_count1", int'(b1.count), 0);
        chk("async_wrap1", int'(b1.wrap), 0);
        clear = 1'b1;
        mc = '{0, 0};
        mw = '{0, 0};
      end
      en = $urandom_range(0, 9) < 8;
      if ($urandom_range(0, 15) == 0) ud = ~ud;
      load = $urandom_range(0, 19) == 0;
      lv = int'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) sat = ~sat;
      apply();
      q.push_back('{mc[0], mc[1], mw[0], mw[1], tc_of(mc[0], mx[0]), tc_of(mc[1], mx[1])});
    end
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
